// File: rtl/br_pkg.sv
// Shared compare-op encodings and 2-bit saturating counter helpers for the
// branch resolve unit and its history table.
package br_pkg;

  typedef enum logic [3:0] {
    OP_EQ  = 4'd0,
    OP_NE  = 4'd1,
    OP_GTZ = 4'd2,
    OP_GEZ = 4'd3,
    OP_LTZ = 4'd4,
    OP_LEZ = 4'd5,
    OP_LT  = 4'd6,
    OP_LTU = 4'd7
  } cmp_op_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Counter moves one step toward the resolved direction, clamping at the ends.
  function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_sat2.sv
// Branch history table of 2-bit saturating counters; read is combinational
// from the current (pre-update) state, so a same-cycle update is not bypassed.
module bht_sat2
  import br_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken
);

  logic [DEPTH-1:0] msb;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [1:0] ctr_q;
      logic [1:0] ctr_d;

      always_comb begin
        ctr_d = ctr_q;
        if (upd_en && (upd_idx == IDX_W'(gi))) begin
          ctr_d = sat2_next(ctr_q, upd_taken);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ctr_q <= WNT;
        end else begin
          ctr_q <= ctr_d;
        end
      end

      assign msb[gi] = ctr_q[1];
    end
  endgenerate

  assign rd_taken = msb[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch compares one cycle after issue and tracks mispredicts.
// Define BRANCH_RESOLVE_BHT_EN to include the 2-bit branch history table.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             cmp_valid,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic [3:0]       cmp_op,
  input  logic [IDX_W-1:0] cmp_idx,
  input  logic             pred_taken,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [31:0]      miss_count
);

  logic        outcome;
  logic        upd;
  logic        res_valid_q, res_valid_d;
  logic        res_taken_q, res_taken_d;
  logic        res_mispredict_q, res_mispredict_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Zero-compares look only at cmp_a; sign bit plus an all-zero test covers them.
  always_comb begin
    outcome = 1'b0;
    case (cmp_op)
      OP_EQ:   outcome = (cmp_a == cmp_b);
      OP_NE:   outcome = (cmp_a != cmp_b);
      OP_GTZ:  outcome = !cmp_a[WIDTH-1] && (|cmp_a);
      OP_GEZ:  outcome = !cmp_a[WIDTH-1];
      OP_LTZ:  outcome = cmp_a[WIDTH-1];
      OP_LEZ:  outcome = cmp_a[WIDTH-1] || !(|cmp_a);
      OP_LT:   outcome = ($signed(cmp_a) < $signed(cmp_b));
      OP_LTU:  outcome = (cmp_a < cmp_b);
      default: outcome = 1'b0;
    endcase
  end

  assign upd = !stall && cmp_valid;

  always_comb begin
    res_valid_d      = res_valid_q;
    res_taken_d      = res_taken_q;
    res_mispredict_d = res_mispredict_q;
    miss_count_d     = miss_count_q;
    if (!stall) begin
      res_valid_d      = cmp_valid;
      res_taken_d      = cmp_valid && outcome;
      res_mispredict_d = cmp_valid && (outcome ^ pred_taken);
      if (upd && (outcome ^ pred_taken) && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      miss_count_q     <= 32'd0;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      miss_count_q     <= miss_count_d;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign miss_count     = miss_count_q;

`ifdef BRANCH_RESOLVE_BHT_EN
  bht_sat2 #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .upd_en    (upd),
    .upd_idx   (cmp_idx),
    .upd_taken (outcome),
    .rd_idx    (lookup_idx),
    .rd_taken  (lookup_taken)
  );
`else
  // Table indices have no consumer without the history table.
  logic unused_idx;
  assign unused_idx   = ^{cmp_idx, lookup_idx, upd};
  assign lookup_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue scoreboard; table
// expectations follow BRANCH_RESOLVE_BHT_EN.
module tb_branch_resolve_unit;

  localparam int DEPTH = 64;
  localparam int IW    = 6;
`ifdef BRANCH_RESOLVE_BHT_EN
  localparam bit BHT_EN = 1'b1;
`else
  localparam bit BHT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic        mis;
    logic [31:0] miss;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          cmp_valid;
  logic [31:0]   cmp_a;
  logic [31:0]   cmp_b;
  logic [3:0]    cmp_op;
  logic [IW-1:0] cmp_idx;
  logic          pred_taken;
  logic [IW-1:0] lookup_idx;
  logic          lookup_taken;
  logic          res_valid;
  logic          res_taken;
  logic          res_mispredict;
  logic [31:0]   miss_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;
  exp_t exp_q[$];
  exp_t m_res;
  logic [31:0] m_miss;
  logic [1:0]  m_bht [DEPTH];

  branch_resolve_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .cmp_valid      (cmp_valid),
    .cmp_a          (cmp_a),
    .cmp_b          (cmp_b),
    .cmp_op         (cmp_op),
    .cmp_idx        (cmp_idx),
    .pred_taken     (pred_taken),
    .lookup_idx     (lookup_idx),
    .lookup_taken   (lookup_taken),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0:    return a == b;
      4'd1:    return a != b;
      4'd2:    return sa > 0;
      4'd3:    return sa >= 0;
      4'd4:    return sa < 0;
      4'd5:    return sa <= 0;
      4'd6:    return sa < sb;
      4'd7:    return a < b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, res_valid}, {31'd0, e.valid});
    check({tag, "_taken"}, {31'd0, res_taken}, {31'd0, e.taken});
    check({tag, "_mispredict"}, {31'd0, res_mispredict}, {31'd0, e.mis});
    check({tag, "_miss_count"}, miss_count, e.miss);
  endtask

  // One clock of stimulus: check the combinational lookup before the edge,
  // advance the model, then compare registered results after the edge.
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [IW-1:0] idx,
                      input logic p, input logic st, input logic [IW-1:0] lidx);
    logic o;
    logic exp_lk;
    @(negedge clk);
    reset = 1'b0; cmp_valid = v; cmp_op = op; cmp_a = a; cmp_b = b;
    cmp_idx = idx; pred_taken = p; stall = st; lookup_idx = lidx;
    #1;
    exp_lk = BHT_EN ? m_bht[lidx][1] : 1'b0;
    check({tag, "_lookup"}, {31'd0, lookup_taken}, {31'd0, exp_lk});
    if (!st) begin
      o = ref_cmp(op, a, b);
      m_res.valid = v;
      m_res.taken = v & o;
      m_res.mis   = v & (o ^ p);
      if (v) begin
        if (o && m_bht[idx] != 2'd3) m_bht[idx] = m_bht[idx] + 2'd1;
        if (!o && m_bht[idx] != 2'd0) m_bht[idx] = m_bht[idx] - 2'd1;
        if ((o ^ p) && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
      end
    end
    m_res.miss = m_miss;
    exp_q.push_back(m_res);
    @(posedge clk);
    #1;
    n_step++;
    $display("[TB] step %0d %s v=%0b op=%0d st=%0b lk=%0b res=%0b/%0b/%0b miss=%h",
             n_step, tag, v, op, st, lookup_taken, res_valid, res_taken, res_mispredict, miss_count);
    check_res(tag);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; stall = 1'b1; cmp_valid = 1'b1; cmp_op = 4'd0;
    cmp_a = 32'd0; cmp_b = 32'd0; cmp_idx = '0; pred_taken = 1'b0; lookup_idx = '0;
    repeat (cycles) @(posedge clk);
    #1;
    m_miss = 32'd0;
    m_res  = '0;
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 2'b01;
    exp_q.push_back(m_res);
    $display("[TB] reset res=%0b/%0b/%0b miss=%h", res_valid, res_taken, res_mispredict, miss_count);
    check_res("reset");
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; cmp_valid = 1'b0; cmp_op = 4'd0;
    cmp_a = 32'd0; cmp_b = 32'd0; cmp_idx = '0; pred_taken = 1'b0; lookup_idx = '0;
    m_miss = 32'd0;
    m_res  = '0;

    // Reset with a mispredicting branch presented: must be discarded.
    do_reset(2);

    for (int i = 0; i < DEPTH; i++) step("lookup_all", 1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0, IW'(i));

    step("ltu_max", 1'b1, 4'd7, 32'd1, 32'hFFFF_FFFF, 6'd0, 1'b0, 1'b0, 6'd0);
    step("lt_neg",  1'b1, 4'd6, 32'hFFFF_FFFF, 32'd1, 6'd1, 1'b1, 1'b0, 6'd0);
    step("gez_min", 1'b1, 4'd3, 32'h8000_0000, 32'd0, 6'd2, 1'b0, 1'b0, 6'd1);
    step("op9",     1'b1, 4'd9, 32'd0, 32'd0, 6'd3, 1'b1, 1'b0, 6'd2);
    step("eq",      1'b1, 4'd0, 32'h1234, 32'h1234, 6'd4, 1'b1, 1'b0, 6'd3);
    step("ne",      1'b1, 4'd1, 32'h1234, 32'h1234, 6'd4, 1'b1, 1'b0, 6'd4);
    step("gtz_zero",1'b1, 4'd2, 32'd0, 32'd5, 6'd6, 1'b0, 1'b0, 6'd4);
    step("gtz_pos", 1'b1, 4'd2, 32'd3, 32'hFFFF_FFFF, 6'd6, 1'b0, 1'b0, 6'd6);
    step("ltz_neg", 1'b1, 4'd4, 32'hFFFF_FFF0, 32'd0, 6'd8, 1'b1, 1'b0, 6'd6);
    step("lez_zero",1'b1, 4'd5, 32'd0, 32'h8000_0000, 6'd8, 1'b0, 1'b0, 6'd8);
    step("lez_pos", 1'b1, 4'd5, 32'd1, 32'd0, 6'd9, 1'b0, 1'b0, 6'd8);
    step("ltu_eq",  1'b1, 4'd7, 32'd7, 32'd7, 6'd9, 1'b0, 1'b0, 6'd9);
    step("op15",    1'b1, 4'd15, 32'd1, 32'd2, 6'd9, 1'b1, 1'b0, 6'd9);

    for (int i = 0; i < 4; i++) step("idx5_taken", 1'b1, 4'd0, 32'd0, 32'd0, 6'd5, 1'b1, 1'b0, 6'd5);
    for (int i = 0; i < 3; i++) step("idx5_not", 1'b1, 4'd1, 32'd0, 32'd0, 6'd5, 1'b0, 1'b0, 6'd5);
    step("idx5_read", 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0, 6'd5);
    step("idx5_up", 1'b1, 4'd0, 32'd0, 32'd0, 6'd5, 1'b0, 1'b0, 6'd5);
    step("idx5_up2", 1'b1, 4'd0, 32'd0, 32'd0, 6'd5, 1'b1, 1'b0, 6'd5);

    for (int i = 0; i < 3; i++) step("stall", 1'b1, 4'd1, 32'd0, 32'd0, 6'd5, 1'b1, 1'b1, 6'd5);
    step("after_stall", 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0, 6'd5);

    step("bypass7_a", 1'b1, 4'd0, 32'd0, 32'd0, 6'd7, 1'b1, 1'b0, 6'd7);
    step("bypass7_b", 1'b1, 4'd0, 32'd0, 32'd0, 6'd7, 1'b1, 1'b0, 6'd7);

    // Preload the counter near its ceiling; one idle edge latches it in the flop.
    @(negedge clk);
    force dut.miss_count_q = 32'hFFFF_FFFE;
    m_miss = 32'hFFFF_FFFE;
    step("preload", 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    release dut.miss_count_q;
    for (int i = 0; i < 3; i++) step("miss_sat", 1'b1, 4'd0, 32'd1, 32'd1, 6'd10, 1'b0, 1'b0, 6'd10);
    step("idle_end", 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0, 6'd10);

    do_reset(1);
    step("post_reset", 1'b0, 4'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0, 6'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
